demux_frame_sequencer: RTL
==========================

Name: demux_frame_sequencer

Overview:
Upstream driver for the 1:8 demultiplexer stage. It accepts an 8-bit frame over a valid/ready handshake, then drives the demux `data`/`sel` inputs one channel at a time. In sweep mode it steps through channels 0..7. In single mode it drives only one addressed channel. Each channel is held for a programmable dwell time, and a done pulse marks frame completion, so the demux outputs can be sequenced without external control logic.

Parameters:
DWELL, 1, cycles each channel is held on data/sel; legal range 1..255; 0 is illegal (elaboration-time error).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  frame request valid
in_ready  output  1  block can accept a frame
in_frame  input  8  frame bits; bit i is routed to channel i
in_mode  input  1  0 = sweep all 8 channels, 1 = single channel
in_chan  input  3  target channel in single mode; ignored in sweep mode
data  output  1  serial data to demux data input
sel  output  3  channel select to demux sel input
out_active  output  1  data/sel currently carry a valid channel drive
busy  output  1  frame in progress (equals out_active)
done  output  1  one-cycle pulse after the last channel of a frame

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous and active-high.
- Reset values (the edge with rst=1): state IDLE, data=0, sel=0, out_active=0, busy=0, done=0, in_ready=1, dwell counter=0, channel counter=0.
- All outputs are registered. in_ready is a decode of state: 1 in IDLE, 0 in DRIVE.
- States: IDLE and DRIVE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready at a clock edge.
  - On accept, latch in_frame, in_mode and in_chan into internal registers; go to DRIVE.
  - On that same edge: out_active=1, busy=1, dwell counter=0.
  - Sweep: sel=0, data=in_frame[0].
  - Single: sel=in_chan, data=in_frame[in_chan].
- DRIVE, hold phase:
  - data/sel are held while the dwell counter counts 0..DWELL-1.
  - When the counter reaches DWELL-1, the channel is finished.
- DRIVE, channel finished:
  - Sweep with sel<7: sel increments by 1; data=latched_frame[sel+1]; dwell counter resets to 0.
  - Sweep with sel=7, or single mode: go to IDLE; data=0, sel=0, out_active=0, busy=0, done=1.
- done is high for exactly one cycle, the first IDLE cycle.
- A new frame may be accepted in the done cycle (in_ready=1). Back-to-back frames therefore have exactly one inactive cycle between them.
- Latency: accept at edge k; outputs active for cycles k+1..k+N*DWELL, where N=8 (sweep) or N=1 (single); done is high in cycle k+N*DWELL+1.
- Zero frame bits are still driven: data=0 with sel valid, so all demux outputs stay low for that slot.
- Inputs changing during DRIVE have no effect. in_valid during DRIVE is not accepted, and no request is queued.
- Reset asserted mid-frame: abort on that edge, return to reset values, no done pulse.
- sel never exceeds 7, and the channel counter never wraps within a frame.
- data is never 1 while out_active=0.

Test Plan:
- Reset then idle, in_valid=0 for 10 cycles -> in_ready=1, out_active=0, data=0, sel=0, done=0 throughout.
- DWELL=1, sweep, in_frame=8'hA5 -> 8 active cycles with sel=0..7 and data=1,0,1,0,0,1,0,1; done one cycle later; in_ready=0 during drive.
- DWELL=3, single mode, in_chan=6, in_frame=8'h40 -> sel=6, data=1 for exactly 3 cycles; done next cycle; total accept-to-done latency 4 cycles.
- Back-to-back: in_valid held high with frames 8'hFF then 8'h01 (sweep, DWELL=1) -> second frame accepted in the done cycle of the first; exactly one inactive cycle between frames; in_valid pulses during DRIVE are ignored.
- Reset mid-sweep at sel=4 (DWELL=2) -> next cycle all outputs at reset values, no done pulse; a new 8'h0F frame then completes normally.
- Input stability: change in_frame, in_chan and in_mode every cycle during a single-mode frame (chan=2, frame=8'h04) -> outputs reflect only the latched values (sel=2, data=1).

Source files
------------

// File: rtl/demux_frame_sequencer.sv
// Frame sequencer for the 1:8 demux stage: accepts one 8-bit frame, then drives
// data/sel one channel at a time (sweep 0..7 or a single addressed channel).
module demux_frame_sequencer #(
  parameter int unsigned DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_frame,
  input  logic       in_mode,
  input  logic [2:0] in_chan,
  output logic       data,
  output logic [2:0] sel,
  output logic       out_active,
  output logic       busy,
  output logic       done
);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("demux_frame_sequencer: DWELL must be in 1..255");
  end

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic       mode_q, mode_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] sel_q, sel_d;
  logic       data_q, data_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic [2:0] next_sel;
  logic [2:0] accept_sel;

  assign next_sel   = sel_q + 3'd1;
  assign accept_sel = in_mode ? in_chan : 3'd0;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d  = state_q;
    frame_d  = frame_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    sel_d    = sel_q;
    data_d   = data_q;
    active_d = active_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = DRIVE;
          frame_d  = in_frame;
          mode_d   = in_mode;
          dwell_d  = 8'd0;
          sel_d    = accept_sel;
          data_d   = in_frame[accept_sel];
          active_d = 1'b1;
        end
      end
      DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          // Sweep advances until channel 7; single mode ends after its one slot.
          if (!mode_q && sel_q != 3'd7) begin
            sel_d  = next_sel;
            data_d = frame_q[next_sel];
          end else begin
            state_d  = IDLE;
            sel_d    = 3'd0;
            data_d   = 1'b0;
            active_d = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= 8'd0;
      mode_q   <= 1'b0;
      dwell_q  <= 8'd0;
      sel_q    <= 3'd0;
      data_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign data       = data_q;
  assign sel        = sel_q;
  assign out_active = active_q;
  assign busy       = active_q;
  assign done       = done_q;

endmodule
